// File: rtl/run_arbiter.sv
// run_arbiter: round-robin sharing of one run-handshake compute core among
// N requesters. One operation is outstanding at a time. The winner's operand
// is registered and held for the whole transaction. A one-cycle run request is
// issued to the core, then the core's busy rise and fall are tracked. The
// result is captured and returned to the owner together with a one-cycle done
// pulse.
//
// Handshake summary: o_run_req is a single-cycle pulse, and the core accepts
// o_run_input_a_0 in that cycle. The core then raises i_run_busy while it is
// working and drops it once i_run_return is valid. A core that never raises
// busy within START_WAIT cycles is treated as zero-latency, and i_run_return
// is taken as the result. o_done[k] is a one-cycle pulse to owner k, and
// o_result is valid in the same cycle. Requesters hold i_req until done, but
// i_req is sampled only while idle.
module run_arbiter #(
    parameter int N          = 4,
    parameter int W          = 32,
    parameter int START_WAIT = 8
) (
    input  logic           clock,
    input  logic           reset,
    input  logic           ce,
    input  logic [N-1:0]   i_req,
    input  logic [N*W-1:0] i_operand,
    output logic [N-1:0]   o_grant,
    output logic [N-1:0]   o_done,
    output logic [W-1:0]   o_result,
    output logic           o_busy,
    output logic           o_run_req,
    output logic [W-1:0]   o_run_input_a_0,
    input  logic           i_run_busy,
    input  logic [W-1:0]   i_run_return
);

    localparam int PW = (N > 1) ? $clog2(N) : 1;
    localparam int CW = $clog2(START_WAIT + 1);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        ISSUE     = 3'd1,
        WAIT_BUSY = 3'd2,
        WAIT_DONE = 3'd3,
        RESPOND   = 3'd4
    } state_t;

    state_t          state_q, state_d;
    logic [PW-1:0]   ptr_q, ptr_d;
    logic [PW-1:0]   own_q, own_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [N-1:0]    grant_q, grant_d;
    logic [N-1:0]    done_q, done_d;
    logic [W-1:0]    result_q, result_d;
    logic            run_req_q, run_req_d;
    logic [W-1:0]    operand_q, operand_d;

    logic            pick_valid;
    logic [PW-1:0]   pick_idx;
    logic [PW-1:0]   cand;

    // Round-robin search: first requester at or above the pointer, wrapping.
    always_comb begin
        pick_valid = 1'b0;
        pick_idx   = '0;
        cand       = '0;
        for (int i = 0; i < N; i++) begin
            cand = PW'((int'(ptr_q) + i) % N);
            if (!pick_valid && i_req[cand]) begin
                pick_valid = 1'b1;
                pick_idx   = cand;
            end
        end
    end

    // Next-state and registered-output logic for the transaction sequence.
    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        own_d     = own_q;
        cnt_d     = cnt_q;
        grant_d   = grant_q;
        done_d    = '0;
        result_d  = result_q;
        run_req_d = 1'b0;
        operand_d = operand_q;
        case (state_q)
            IDLE: begin
                if (pick_valid) begin
                    own_d     = pick_idx;
                    grant_d   = N'(1) << pick_idx;
                    operand_d = i_operand[pick_idx*W +: W];
                    run_req_d = 1'b1;
                    state_d   = ISSUE;
                end
            end
            ISSUE: begin
                cnt_d   = '0;
                state_d = WAIT_BUSY;
            end
            WAIT_BUSY: begin
                if (i_run_busy) begin
                    state_d = WAIT_DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                    // Core never acknowledged: treat it as zero-latency.
                    if (cnt_q + 1'b1 == CW'(START_WAIT)) begin
                        result_d = i_run_return;
                        done_d   = grant_q;
                        state_d  = RESPOND;
                    end
                end
            end
            WAIT_DONE: begin
                if (!i_run_busy) begin
                    result_d = i_run_return;
                    done_d   = grant_q;
                    state_d  = RESPOND;
                end
            end
            RESPOND: begin
                ptr_d   = (own_q == PW'(N - 1)) ? '0 : own_q + 1'b1;
                grant_d = '0;
                state_d = IDLE;
            end
            default: begin
                grant_d = '0;
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers; reset wins over the clock enable.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= IDLE;
            ptr_q     <= '0;
            own_q     <= '0;
            cnt_q     <= '0;
            grant_q   <= '0;
            done_q    <= '0;
            result_q  <= '0;
            run_req_q <= 1'b0;
            operand_q <= '0;
        end else if (ce) begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            own_q     <= own_d;
            cnt_q     <= cnt_d;
            grant_q   <= grant_d;
            done_q    <= done_d;
            result_q  <= result_d;
            run_req_q <= run_req_d;
            operand_q <= operand_d;
        end
    end

    assign o_grant         = grant_q;
    assign o_done          = done_q;
    assign o_result        = result_q;
    assign o_busy          = (state_q != IDLE);
    assign o_run_req       = run_req_q;
    assign o_run_input_a_0 = operand_q;

endmodule

// File: tb/tb_run_arbiter.sv
// Bench for run_arbiter: a core model that answers run requests, a
// transaction-level reference model checked every cycle, a result scoreboard,
// and directed scenarios with hand-computed expectations.
module tb_run_arbiter;

    localparam int N          = 4;
    localparam int W          = 32;
    localparam int START_WAIT = 8;
    localparam logic [W-1:0] DOUBLE = 32'h0080_0000;  // exponent +1 == x+x

    logic           clock = 1'b0;
    logic           reset = 1'b1;
    logic           ce = 1'b1;
    logic [N-1:0]   i_req = '0;
    logic [N*W-1:0] i_operand = '0;
    logic [N-1:0]   o_grant, o_done;
    logic [W-1:0]   o_result, o_run_input_a_0;
    logic           o_busy, o_run_req;
    logic           i_run_busy = 1'b0;
    logic [W-1:0]   i_run_return = '0;

    int n_cmp = 0;
    int n_err = 0;
    bit chk_en = 1'b0;

    run_arbiter #(.N(N), .W(W), .START_WAIT(START_WAIT)) dut (
        .clock(clock), .reset(reset), .ce(ce),
        .i_req(i_req), .i_operand(i_operand),
        .o_grant(o_grant), .o_done(o_done), .o_result(o_result),
        .o_busy(o_busy), .o_run_req(o_run_req),
        .o_run_input_a_0(o_run_input_a_0),
        .i_run_busy(i_run_busy), .i_run_return(i_run_return)
    );

    // Clock and watchdog.
    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Core model: a run request starts core_len busy cycles (0 = never busy,
    // answer immediately); the answer is the operand doubled.
    int           core_len = 3;
    int           core_cnt = 0;
    logic [W-1:0] core_pend = '0;

    always @(posedge clock) begin
        logic req_s, ce_s, rst_s;
        logic [W-1:0] op_s;
        req_s = o_run_req;
        ce_s  = ce;
        rst_s = reset;
        op_s  = o_run_input_a_0;
        #1;
        if (rst_s) begin
            core_cnt   = 0;
            i_run_busy = 1'b0;
        end else if (ce_s) begin
            if (req_s) begin
                core_pend = op_s + DOUBLE;
                if (core_len == 0) begin
                    i_run_return = core_pend;
                end else begin
                    core_cnt     = core_len;
                    i_run_busy   = 1'b1;
                    i_run_return = 32'hdead_beef;
                end
            end else if (core_cnt > 0) begin
                core_cnt--;
                if (core_cnt == 0) begin
                    i_run_busy   = 1'b0;
                    i_run_return = core_pend;
                end
            end
        end
    end

    // Reference model at transaction level: owner index (-1 idle), cycles
    // since the grant, whether the core has shown busy, and a finish flag for
    // the cycle the answer is handed back.
    int           m_owner = -1;
    int           m_ptr = 0;
    int           m_step = 0;
    bit           m_seen = 1'b0;
    bit           m_finish = 1'b0;
    bit           m_popped = 1'b0;
    logic [W-1:0] m_result = '0;
    logic [W-1:0] m_operand = '0;
    logic [W-1:0] exp_q[$];

    always @(posedge clock) begin
        if (reset) begin
            m_owner   = -1;
            m_ptr     = 0;
            m_finish  = 1'b0;
            m_result  = '0;
            m_operand = '0;
            exp_q.delete();
        end else if (ce) begin
            if (m_owner < 0) begin
                for (int i = 0; i < N; i++) begin
                    int k;
                    k = (m_ptr + i) % N;
                    if (m_owner < 0 && i_req[k]) begin
                        m_owner   = k;
                        m_operand = i_operand[k*W +: W];
                        m_step    = 0;
                        m_seen    = 1'b0;
                        exp_q.push_back(m_operand + DOUBLE);
                    end
                end
            end else if (m_finish) begin
                m_ptr    = (m_owner + 1) % N;
                m_owner  = -1;
                m_finish = 1'b0;
            end else if (m_step == 0) begin
                m_step = 1;
            end else begin
                if (i_run_busy) begin
                    m_seen = 1'b1;
                end else if (m_seen || m_step == START_WAIT) begin
                    m_finish = 1'b1;
                    m_popped = 1'b0;
                    m_result = i_run_return;
                end
                m_step++;
            end
        end
    end

    // Compare process: every cycle on the falling edge.
    always @(negedge clock) begin
        logic [N-1:0] eg, ed;
        if (chk_en) begin
            eg = '0;
            ed = '0;
            if (m_owner >= 0) begin
                eg[m_owner] = 1'b1;
                if (m_finish) ed[m_owner] = 1'b1;
            end
            check("grant", 32'(o_grant), 32'(eg));
            check("done", 32'(o_done), 32'(ed));
            check("busy", 32'(o_busy), 32'(m_owner >= 0));
            check("run_req", 32'(o_run_req), 32'(m_owner >= 0 && m_step == 0 && !m_finish));
            check("result", o_result, m_result);
            check("operand", o_run_input_a_0, m_operand);
            if (m_finish && !m_popped) begin
                m_popped = 1'b1;
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL scoreboard: done with no expected result queued");
                end else begin
                    check("scoreboard", o_result, exp_q.pop_front());
                end
            end
        end
    end

    // Driver tasks.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        i_req = '0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic set_op(input int k, input logic [W-1:0] v);
        i_operand[k*W +: W] = v;
    endtask

    // Counts edges until a done pulse is visible, bounded.
    task automatic wait_done(output int lat);
        lat = 0;
        do begin
            tick();
            lat++;
        end while (o_done == '0 && lat < 200);
        if (o_done == '0) begin
            n_cmp++;
            n_err++;
            $display("FAIL done_timeout: got no done expected a pulse");
        end
    endtask

    logic [N-1:0] order[5];

    initial begin
        int lat;
        apply_reset();
        chk_en = 1'b1;

        // 1: single requester, 3-cycle core
        core_len = 3;
        set_op(0, 32'h3fa6_6666);
        i_req = 4'b0001;
        tick();
        check("t1_run_req", 32'(o_run_req), 32'd1);
        check("t1_operand", o_run_input_a_0, 32'h3fa6_6666);
        check("t1_grant", 32'(o_grant), 32'h1);
        wait_done(lat);
        check("t1_latency", lat, 32'd5);
        check("t1_done", 32'(o_done), 32'h1);
        check("t1_result", o_result, 32'h4026_6666);
        i_req = '0;
        tick();

        // 2: all requesting, round-robin order 0,1,2,3,0
        apply_reset();
        core_len = 2;
        for (int k = 0; k < N; k++) set_op(k, 32'h3f80_0000 + 32'(k) * 32'h0010_0000);
        order[0] = 4'b0001; order[1] = 4'b0010; order[2] = 4'b0100;
        order[3] = 4'b1000; order[4] = 4'b0001;
        i_req = 4'b1111;
        for (int g = 0; g < 5; g++) begin
            wait_done(lat);
            check("t2_done_order", 32'(o_done), 32'(order[g]));
        end
        i_req = '0;
        tick();

        // 3: core never busy -> timeout path
        apply_reset();
        core_len = 0;
        set_op(1, 32'h1234_5678);
        i_req = 4'b0010;
        tick();
        check("t3_run_req", 32'(o_run_req), 32'd1);
        wait_done(lat);
        check("t3_latency", lat, 32'd9);
        check("t3_done", 32'(o_done), 32'h2);
        check("t3_result", o_result, 32'h12b4_5678);
        i_req = '0;
        tick();

        // 4: clock enable low for 5 cycles inside WAIT_DONE
        apply_reset();
        core_len = 3;
        set_op(1, 32'h4049_0fdb);
        i_req = 4'b0010;
        tick();
        tick();
        tick();
        ce = 1'b0;
        for (int c = 0; c < 5; c++) begin
            tick();
            check("t4_frozen_grant", 32'(o_grant), 32'h2);
            check("t4_frozen_done", 32'(o_done), 32'h0);
        end
        ce = 1'b1;
        wait_done(lat);
        check("t4_latency", 32'(lat + 7), 32'd10);
        check("t4_result", o_result, 32'h40c9_0fdb);
        i_req = '0;
        tick();

        // 5: reset mid-transaction, pointer returns to 0
        apply_reset();
        core_len = 3;
        set_op(1, 32'h3f00_0000);
        set_op(3, 32'h4100_0000);
        i_req = 4'b0010;
        tick();
        wait_done(lat);
        i_req = '0;
        tick();
        i_req = 4'b1000;
        tick();
        check("t5_grant3", 32'(o_grant), 32'h8);
        tick();
        tick();
        reset = 1'b1;
        tick();
        check("t5_rst_grant", 32'(o_grant), 32'h0);
        check("t5_rst_done", 32'(o_done), 32'h0);
        check("t5_rst_busy", 32'(o_busy), 32'h0);
        check("t5_rst_result", o_result, 32'h0);
        check("t5_rst_operand", o_run_input_a_0, 32'h0);
        reset = 1'b0;
        i_req = 4'b0110;
        tick();
        check("t5_grant_after_rst", 32'(o_grant), 32'h2);
        wait_done(lat);
        check("t5_done", 32'(o_done), 32'h2);
        i_req = '0;
        tick();

        // 6: requester drops i_req right after grant
        apply_reset();
        core_len = 4;
        set_op(2, 32'h4000_0000);
        i_req = 4'b0100;
        tick();
        check("t6_grant", 32'(o_grant), 32'h4);
        i_req = '0;
        wait_done(lat);
        check("t6_latency", lat, 32'd6);
        check("t6_done", 32'(o_done), 32'h4);
        check("t6_result", o_result, 32'h4080_0000);
        tick();
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
